// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and prescaler helper for the UART receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // Rounded clocks per oversample tick, minus one (the down-counter reload).
  function automatic int calc_reload(input int sys_clk, input int baud_rate, input int division);
    int per_tick;
    per_tick = baud_rate * division;
    return (sys_clk + per_tick / 2) / per_tick - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: one-clock tick every RELOAD+1 clocks, restartable.
module uart_baud_tick #(
  parameter int RELOAD = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (RELOAD > 0) ? $clog2(RELOAD + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || r_cnt == '0) begin
      r_cnt <= CW'(RELOAD);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with majority vote and valid/ready output.
// Optional break detection when UART_RX_BREAK_DET_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int SYS_CLK   = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DIVISION  = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_d,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 o_break
`endif
);

  localparam int RELOAD = calc_reload(SYS_CLK, BAUD_RATE, DIVISION);
  localparam int SW     = $clog2(DIVISION);
  localparam int MID    = DIVISION / 2;
  localparam int BW     = 4;

  state_t               r_state, w_next;
  logic [1:0]           r_sync, r_fill;
  logic                 r_armed;
  logic [SW-1:0]        r_s, w_s_nxt;
  logic                 r_v0, r_v1;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_par_err, r_frm_err;
  logic                 r_valid, r_par_out, r_frm_out, r_overrun;
  logic                 w_rx, w_tick, w_start_det, w_dec, w_vote;
  logic                 w_last_data, w_last_stop, w_done, w_break, w_load;
`ifdef UART_RX_BREAK_DET_EN
  logic                 r_all_zero, r_break, w_brk_release;
`endif

  uart_baud_tick #(.RELOAD(RELOAD)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_start_det),
    .o_tick    (w_tick)
  );

  assign w_rx        = r_sync[1];
  assign w_start_det = (r_state == S_IDLE) && w_tick && !w_rx && r_armed;
  assign w_s_nxt     = (r_s == SW'(DIVISION - 1)) ? '0 : r_s + 1'b1;
  assign w_dec       = w_tick && (w_s_nxt == SW'(MID + 1)) &&
                       (r_state inside {S_START, S_DATA, S_PARITY, S_STOP});
  assign w_vote      = (r_v0 & r_v1) | (r_v0 & w_rx) | (r_v1 & w_rx);
  assign w_last_data = (r_bit_cnt == BW'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BW'(STOP_BITS - 1));
  assign w_done      = (r_state == S_STOP) && w_dec && w_last_stop;
`ifdef UART_RX_BREAK_DET_EN
  assign w_break       = w_done && r_all_zero && !w_vote;
  assign w_brk_release = (r_state == S_BRK_WAIT) && w_tick && w_rx &&
                         (r_s == SW'(DIVISION - 1));
`else
  assign w_break = 1'b0;
`endif
  assign w_load = w_done && !w_break;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: next state defaults to the current state so this block never infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_det) w_next = S_START;
      S_START:  if (w_dec) w_next = w_vote ? S_IDLE : S_DATA;
      S_DATA:   if (w_dec && w_last_data)
                  w_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (w_dec) w_next = S_STOP;
`ifdef UART_RX_BREAK_DET_EN
      S_STOP:     if (w_done) w_next = w_break ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (w_brk_release) w_next = S_IDLE;
`else
      S_STOP:     if (w_done) w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: synchronous reset; the synchroniser resets to idle-high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_fill    <= '0;
      r_armed   <= 1'b0;
      r_s       <= '0;
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_out <= 1'b0;
      r_frm_out <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_all_zero <= 1'b0;
      r_break    <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], i_rx_d};
      r_fill <= {r_fill[0], 1'b1};
      // Arm only once a genuine pin sample has reached the synchroniser output and is high.
      if (r_fill[1] && w_rx) r_armed <= 1'b1;

      if (w_start_det) r_s <= '0;
`ifdef UART_RX_BREAK_DET_EN
      else if (w_break) r_s <= '0;
      else if (r_state == S_BRK_WAIT && w_tick) r_s <= w_rx ? w_s_nxt : '0;
`endif
      else if (w_tick) r_s <= w_s_nxt;

      if (w_tick && w_s_nxt == SW'(MID - 1)) r_v0 <= w_rx;
      if (w_tick && w_s_nxt == SW'(MID))     r_v1 <= w_rx;

      if (w_start_det) begin
        r_bit_cnt <= '0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end else if (w_dec) begin
        case (r_state)
          S_DATA: begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + 1'b1;
          end
          S_PARITY: begin
            r_par_err <= (PARITY == PARITY_EVEN) ? (w_vote ^ (^r_shift))
                                                 : ~(w_vote ^ (^r_shift));
          end
          S_STOP: begin
            r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + 1'b1;
            if (!w_vote) r_frm_err <= 1'b1;
          end
          default: r_bit_cnt <= '0;
        endcase
      end

`ifdef UART_RX_BREAK_DET_EN
      if (r_state == S_START && w_dec) r_all_zero <= 1'b1;
      else if (w_dec)                  r_all_zero <= r_all_zero & ~w_vote;
      r_break <= w_break;
`endif

      if (w_load && (!r_valid || i_ready)) begin
        r_data    <= r_shift;
        r_par_out <= (PARITY != PARITY_NONE) && r_par_err;
        r_frm_out <= r_frm_err | ~w_vote;
        r_valid   <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      r_overrun <= w_load && r_valid && !i_ready;
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_par_out;
  assign o_frame_err  = r_frm_out;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_state inside {S_DATA, S_PARITY, S_STOP};
`ifdef UART_RX_BREAK_DET_EN
  assign o_break      = r_break;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance plus an even-parity instance.
// Break-detect checks are built when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_param;

  localparam int BIT_CLKS  = 432;  // 27 clocks per tick * 16 ticks per bit
  localparam int TICK_CLKS = 27;
  localparam int CLK_PER   = 10;

  logic       clk, rst;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       valid0, perr0, ferr0, ovr0, busy0;
  logic       valid1, perr1, ferr1, ovr1, busy1;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk0, brk1;
  int         brk_cnt = 0;
  int         brk_base;
`endif

  int     passed = 0;
  int     total  = 0;
  int     ovr_cnt = 0;
  int     ovr_base;
  int     d;
  logic   busy0_q = 1'b0;
  longint fall_t = 0;
  longint s1, f1;

  uart_rx_param u_dut0 (
    .clk (clk), .rst (rst), .i_rx_d (rx0), .i_ready (rdy0),
    .o_data (data0), .o_valid (valid0), .o_parity_err (perr0),
    .o_frame_err (ferr0), .o_overrun (ovr0), .o_busy (busy0)
`ifdef UART_RX_BREAK_DET_EN
    , .o_break (brk0)
`endif
  );

  uart_rx_param #(.PARITY(1)) u_dut1 (
    .clk (clk), .rst (rst), .i_rx_d (rx1), .i_ready (rdy1),
    .o_data (data1), .o_valid (valid1), .o_parity_err (perr1),
    .o_frame_err (ferr1), .o_overrun (ovr1), .o_busy (busy1)
`ifdef UART_RX_BREAK_DET_EN
    , .o_break (brk1)
`endif
  );

  initial clk = 1'b0;
  always #(CLK_PER / 2) clk = ~clk;

  always @(negedge clk) begin
    if (busy0_q && !busy0) fall_t = $time;
    busy0_q = busy0;
    if (ovr0) ovr_cnt++;
`ifdef UART_RX_BREAK_DET_EN
    if (brk0) brk_cnt++;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_line(input int lane, input logic b);
    if (lane == 0) rx0 = b;
    else           rx1 = b;
  endtask

  task automatic drive_bit(input int lane, input logic b);
    set_line(lane, b);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input int lane, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par_bit, input logic stop_val);
    drive_bit(lane, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(lane, data[i]);
    if (par_en) drive_bit(lane, par_bit);
    drive_bit(lane, stop_val);
    set_line(lane, 1'b1);
  endtask

  task automatic ack(input int lane);
    if (lane == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    @(negedge clk);
    if (lane == 0) rdy0 = 1'b0; else rdy1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data0", data0, 32'h0);
    check("rst_outs0", {valid0, perr0, ferr0, ovr0, busy0}, 32'h0);
    check("rst_outs1", {valid1, perr1, ferr1, ovr1, busy1}, 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // 8N1 word, then handshake
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1);
    check("a5_data", data0, 32'hA5);
    check("a5_valid", valid0, 32'h1);
    check("a5_flags", {perr0, ferr0, busy0}, 32'h0);
    ack(0);
    check("a5_ack_valid", valid0, 32'h0);

    // Even parity: 0x3C has four ones, so the correct parity bit is 0
    send_frame(1, 9'h03C, 8, 1, 1'b1, 1'b1);
    check("par1_data", data1, 32'h3C);
    check("par1_err", perr1, 32'h1);
    check("par1_ferr", ferr1, 32'h0);
    ack(1);
    idle_bits(1);
    send_frame(1, 9'h03C, 8, 1, 1'b0, 1'b1);
    check("par0_data", data1, 32'h3C);
    check("par0_err", perr1, 32'h0);
    check("par0_valid", valid1, 32'h1);
    ack(1);

    // Framing error, then a clean frame
    send_frame(0, 9'h055, 8, 0, 1'b0, 1'b0);
    check("frm_data", data0, 32'h55);
    check("frm_err", ferr0, 32'h1);
    check("frm_perr", perr0, 32'h0);
    ack(0);
    idle_bits(2);
    send_frame(0, 9'h012, 8, 0, 1'b0, 1'b1);
    check("after_frm_data", data0, 32'h12);
    check("after_frm_ferr", ferr0, 32'h0);
    ack(0);

    // Short low glitch on an idle line is a false start
    ovr_base = ovr_cnt;
    rx0 = 1'b0;
    repeat (3 * TICK_CLKS) @(negedge clk);
    rx0 = 1'b1;
    idle_bits(2);
    check("glitch_valid", valid0, 32'h0);
    check("glitch_busy", busy0, 32'h0);
    check("glitch_flags", {perr0, ferr0}, 32'h0);
    check("glitch_ovr", ovr_cnt, ovr_base);

    // Overrun: second word dropped while the first is still held
    s1 = $time;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1);
    f1 = fall_t;
    d = int'((f1 - s1) / CLK_PER);
    idle_bits(1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
    check("ovr_count", ovr_cnt, ovr_base + 1);
    check("ovr_data", data0, 32'h11);
    check("ovr_valid", valid0, 32'h1);
    idle_bits(1);
    // Same tick phase as the 0x11 frame, so completion lands d clocks after the start edge
    for (int k = 0; k < TICK_CLKS && ((($time - s1) / CLK_PER) % TICK_CLKS) != 0; k++)
      @(negedge clk);
    fork
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1);
      begin
        repeat (d - 1) @(negedge clk);
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
      end
    join
    check("swap_data", data0, 32'h22);
    check("swap_valid", valid0, 32'h1);
    check("swap_ovr", ovr_cnt, ovr_base + 1);

    // Reset in the middle of the data bits
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    check("mid_busy", busy0, 32'h1);
    rx0 = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_data", data0, 32'h0);
    check("mid_rst_outs", {valid0, perr0, ferr0, ovr0, busy0}, 32'h0);
    rst = 1'b0;
    idle_bits(2);
    check("low_from_rst_busy", busy0, 32'h0);
    check("low_from_rst_valid", valid0, 32'h0);
    rx0 = 1'b1;
    idle_bits(2);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1'b1);
    check("post_rst_data", data0, 32'h81);
    check("post_rst_valid", valid0, 32'h1);
    check("post_rst_flags", {perr0, ferr0}, 32'h0);
    ack(0);

`ifdef UART_RX_BREAK_DET_EN
    brk_base = brk_cnt;
    rx0 = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    rx0 = 1'b1;
    idle_bits(3);
    check("brk_pulses", brk_cnt, brk_base + 1);
    check("brk_valid", valid0, 32'h0);
    check("brk_busy", busy0, 32'h0);
`else
    rx0 = 1'b0;
    repeat (10 * BIT_CLKS) @(negedge clk);
    rx0 = 1'b1;
    idle_bits(2);
    check("zero_data", data0, 32'h0);
    check("zero_ferr", ferr0, 32'h1);
    check("zero_valid", valid0, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
